// File: rtl/complex_mult_twiddle_wn1conj_32b_pipe_pkg.sv
// rtl/complex_mult_twiddle_wn1conj_32b_pipe_pkg.sv - shared FFT constants and packing helper
package fft_pkg;

  // Component width, Q1.15 two's complement
  localparam int DATA_W = 16;

  // sqrt(2)/2 in Q1.15 (23170)
  localparam logic signed [DATA_W-1:0] K_HALFSQRT2 = 16'sh5A82;

  // Register stages between acceptance and emission
  localparam int STAGES = 3;

  // Packs a complex sample as {real, imag}
  function automatic logic [2*DATA_W-1:0] pack_cplx(input logic [DATA_W-1:0] re,
                                                    input logic [DATA_W-1:0] im);
    return {re, im};
  endfunction

endpackage

// File: rtl/complex_mult_twiddle_wn1conj_32b_pipe_if.sv
// rtl/complex_mult_twiddle_wn1conj_32b_pipe_if.sv - sample in/out handshake and overflow status bundle
interface complex_mult_twiddle_wn1conj_32b_pipe_if;
  import fft_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [2*DATA_W-1:0]   a32;
  logic                  out_valid;
  logic                  out_ready;
  logic [2*DATA_W-1:0]   r32;
  logic                  ovf;
  logic                  clr_ovf;

  // Block side: consumes samples, produces results and status
  modport slave (
    input  in_valid, a32, out_ready, clr_ovf,
    output in_ready, out_valid, r32, ovf
  );

  // Environment side: source and sink around the block
  modport master (
    output in_valid, a32, out_ready, clr_ovf,
    input  in_ready, out_valid, r32, ovf
  );
endinterface

// File: rtl/complex_mult_twiddle_wn1conj_32b_pipe_sat.sv
// rtl/complex_mult_twiddle_wn1conj_32b_pipe_sat.sv - Q1.15 product rescale with 16-bit saturation
module sat_shr15_16b
  import fft_pkg::*;
(
  input  logic signed [32:0]       i_prod,
  output logic        [DATA_W-1:0] o_val,
  output logic                     o_sat
);

  logic signed [32:0] w_shr;

  // Arithmetic shift floors toward -inf; clamp anything outside the 16-bit range
  always_comb begin
    w_shr = i_prod >>> 15;
    o_sat = (w_shr > 33'sd32767) || (w_shr < -33'sd32768);
    if (!o_sat)
      o_val = w_shr[DATA_W-1:0];
    else if (w_shr[32])
      o_val = 16'h8000;
    else
      o_val = 16'h7FFF;
  end

endmodule

// File: rtl/complex_mult_twiddle_wn1conj_32b_pipe.sv
// rtl/complex_mult_twiddle_wn1conj_32b_pipe.sv - 3-stage streaming multiply by conjugate twiddle (1+j)/sqrt2
module complex_mult_twiddle_wn1conj_32b_pipe
  import fft_pkg::*;
(
  input  logic                                   i_clk,
  input  logic                                   i_rst_n,
  complex_mult_twiddle_wn1conj_32b_pipe_if.slave bus
);

  logic                     w_adv;
  logic signed [DATA_W-1:0] w_a;
  logic signed [DATA_W-1:0] w_b;
  logic signed [DATA_W:0]   w_d;
  logic signed [DATA_W:0]   w_s;
  logic signed [32:0]       w_pd;
  logic signed [32:0]       w_ps;
  logic        [DATA_W-1:0] w_re;
  logic        [DATA_W-1:0] w_im;
  logic                     w_sat_re;
  logic                     w_sat_im;

  logic                     r_v1;
  logic signed [DATA_W:0]   r_d;
  logic signed [DATA_W:0]   r_s;
  logic                     r_v2;
  logic signed [32:0]       r_pd;
  logic signed [32:0]       r_ps;
  logic                     r_v3;
  logic [2*DATA_W-1:0]      r_r32;
  logic                     r_sat;
  logic                     r_ovf;

  // One global enable: the whole pipe moves unless a result is stuck at the output
  assign w_adv = bus.out_ready | ~r_v3;

  assign w_a = bus.a32[2*DATA_W-1:DATA_W];
  assign w_b = bus.a32[DATA_W-1:0];

  // 16-bit add/sub widened by one bit so neither can overflow
  assign w_d = {w_a[DATA_W-1], w_a} - {w_b[DATA_W-1], w_b};
  assign w_s = {w_a[DATA_W-1], w_a} + {w_b[DATA_W-1], w_b};

  assign w_pd = 33'(r_d) * 33'(K_HALFSQRT2);
  assign w_ps = 33'(r_s) * 33'(K_HALFSQRT2);

  sat_shr15_16b u_sat_re (
    .i_prod (r_pd),
    .o_val  (w_re),
    .o_sat  (w_sat_re)
  );

  sat_shr15_16b u_sat_im (
    .i_prod (r_ps),
    .o_val  (w_im),
    .o_sat  (w_sat_im)
  );

  // Stage 1: exact difference and sum of the input components
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_v1 <= 1'b0;
      r_d  <= '0;
      r_s  <= '0;
    end else if (w_adv) begin
      r_v1 <= bus.in_valid & w_adv;
      r_d  <= w_d;
      r_s  <= w_s;
    end
  end

  // Stage 2: scale both terms by sqrt(2)/2
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_v2 <= 1'b0;
      r_pd <= '0;
      r_ps <= '0;
    end else if (w_adv) begin
      r_v2 <= r_v1;
      r_pd <= w_pd;
      r_ps <= w_ps;
    end
  end

  // Stage 3: rescaled, saturated result plus its per-sample clamp flag
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_v3  <= 1'b0;
      r_r32 <= '0;
      r_sat <= 1'b0;
    end else if (w_adv) begin
      r_v3  <= r_v2;
      r_r32 <= pack_cplx(w_re, w_im);
      r_sat <= w_sat_re | w_sat_im;
    end
  end

  // Sticky overflow: only counts clamped samples the sink actually took; clear wins
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_ovf <= 1'b0;
    else if (bus.clr_ovf)
      r_ovf <= 1'b0;
    else if (r_v3 && bus.out_ready && r_sat)
      r_ovf <= 1'b1;
  end

  assign bus.in_ready  = w_adv;
  assign bus.out_valid = r_v3;
  assign bus.r32       = r_r32;
  assign bus.ovf       = r_ovf;

endmodule

// File: tb/tb_complex_mult_twiddle_wn1conj_32b_pipe.sv
// tb/tb_complex_mult_twiddle_wn1conj_32b_pipe.sv - directed bench for the conjugate twiddle pipe
module tb_complex_mult_twiddle_wn1conj_32b_pipe;
  import fft_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  complex_mult_twiddle_wn1conj_32b_pipe_if bus ();

  complex_mult_twiddle_wn1conj_32b_pipe dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  // Reference: ((a-b)k, (a+b)k) floored by 2^15 and clamped
  function automatic logic [31:0] ref_mult(input logic [31:0] x);
    logic signed [15:0] re, im;
    longint d, s, pd, ps;
    logic [15:0] ore, oim;
    re = x[31:16];
    im = x[15:0];
    d = longint'(re) - longint'(im);
    s = longint'(re) + longint'(im);
    pd = (d * 23170) >>> 15;
    ps = (s * 23170) >>> 15;
    if (pd > 32767) ore = 16'h7FFF; else if (pd < -32768) ore = 16'h8000; else ore = 16'(pd);
    if (ps > 32767) oim = 16'h7FFF; else if (ps < -32768) oim = 16'h8000; else oim = 16'(ps);
    return {ore, oim};
  endfunction

  task automatic test_reset();
    bus.in_valid  = 1'b0;
    bus.a32       = '0;
    bus.out_ready = 1'b1;
    bus.clr_ovf   = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
    checks++; if (bus.r32 !== 32'h0) begin errors++; $display("FAIL reset_r32 got=%h want=00000000", bus.r32); end
    checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b want=0", bus.ovf); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [31:0] vin [3];
    logic [31:0] vexp [3];
    int cnt;
    vin[0] = 32'h4000_0000; vexp[0] = 32'h2D41_2D41;
    vin[1] = 32'h2000_2000; vexp[1] = 32'h0000_2D41;
    vin[2] = 32'h0000_0001; vexp[2] = 32'hFFFF_0000;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.a32 = vin[i];
      cnt = 0;
      do begin
        @(negedge clk);
        bus.in_valid = 1'b0;
        cnt++;
      end while (!bus.out_valid && cnt < 10);
      checks++; if (cnt !== STAGES) begin errors++; $display("FAIL basic_latency[%0d] got=%0d want=%0d", i, cnt, STAGES); end
      checks++; if (bus.r32 !== vexp[i]) begin errors++; $display("FAIL basic_r32[%0d] got=%h want=%h", i, bus.r32, vexp[i]); end
      checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL basic_ovf[%0d] got=%b want=0", i, bus.ovf); end
      @(negedge clk);
    end
  endtask

  task automatic test_ovf();
    int cnt;
    for (int pass = 0; pass < 2; pass++) begin
      bus.in_valid = 1'b1;
      bus.a32 = 32'h7FFF_8000;
      cnt = 0;
      do begin
        @(negedge clk);
        bus.in_valid = 1'b0;
        cnt++;
      end while (!bus.out_valid && cnt < 10);
      checks++; if (bus.r32 !== 32'h7FFF_FFFF) begin errors++; $display("FAIL ovf_r32[%0d] got=%h want=7fffffff", pass, bus.r32); end
      checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL ovf_before_accept[%0d] got=%b want=0", pass, bus.ovf); end
      if (pass == 0) begin
        @(negedge clk);
        checks++; if (bus.ovf !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b want=1", bus.ovf); end
        bus.clr_ovf = 1'b1;
        @(negedge clk);
        bus.clr_ovf = 1'b0;
        checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%b want=0", bus.ovf); end
      end else begin
        bus.clr_ovf = 1'b1;
        @(negedge clk);
        bus.clr_ovf = 1'b0;
        checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL ovf_clr_priority got=%b want=0", bus.ovf); end
        @(negedge clk);
        checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL ovf_after_priority got=%b want=0", bus.ovf); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vec [8];
    logic [31:0] exp_q [$];
    logic [31:0] e;
    logic exp_rdy;
    int sent, got;
    sent = 0;
    got = 0;
    for (int i = 0; i < 8; i++) vec[i] = {16'(16'h0100 * (i + 1)), 16'(16'h0040 * i)};
    for (int cyc = 1; cyc <= 40 && got < 8; cyc++) begin
      @(negedge clk);
      bus.out_ready = !(cyc >= 4 && cyc <= 6);
      bus.in_valid = (sent < 8);
      if (sent < 8) bus.a32 = vec[sent];
      #1;
      exp_rdy = !(bus.out_valid && !bus.out_ready);
      checks++; if (bus.in_ready !== exp_rdy) begin errors++; $display("FAIL b2b_in_ready cyc=%0d got=%b want=%b", cyc, bus.in_ready, exp_rdy); end
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL b2b_extra got=%h want=none", bus.r32);
        end else begin
          e = exp_q.pop_front();
          if (bus.r32 !== e) begin errors++; $display("FAIL b2b_data[%0d] got=%h want=%h", got, bus.r32, e); end
        end
        got++;
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(ref_mult(vec[sent]));
        sent++;
      end
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    checks++; if (got !== 8 || sent !== 8) begin errors++; $display("FAIL b2b_count got=%0d/%0d want=8/8", got, sent); end
    repeat (4) @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got=%b want=0", bus.out_valid); end
  endtask

  task automatic test_round_trip();
    logic signed [15:0] a_re [6];
    logic signed [15:0] a_im [6];
    logic [31:0] fwd [6];
    logic [31:0] res [6];
    int sent, got, dre, dim;
    longint fr, fi;
    sent = 0;
    got = 0;
    for (int i = 0; i < 6; i++) begin
      a_re[i] = 16'($signed($urandom_range(8191, 0)) - 4096);
      a_im[i] = 16'($signed($urandom_range(8191, 0)) - 4096);
      // Forward W8^1 rotator: (a+jb)(1-j)/sqrt2
      fr = ((longint'(a_re[i]) + longint'(a_im[i])) * 23170) >>> 15;
      fi = ((longint'(a_im[i]) - longint'(a_re[i])) * 23170) >>> 15;
      fwd[i] = {16'(fr), 16'(fi)};
    end
    bus.out_ready = 1'b1;
    for (int cyc = 0; cyc < 30 && got < 6; cyc++) begin
      @(negedge clk);
      bus.in_valid = (sent < 6);
      if (sent < 6) bus.a32 = fwd[sent];
      #1;
      if (bus.out_valid) begin res[got] = bus.r32; got++; end
      if (bus.in_valid && bus.in_ready) sent++;
    end
    bus.in_valid = 1'b0;
    checks++; if (got !== 6) begin errors++; $display("FAIL rt_count got=%0d want=6", got); end
    for (int i = 0; i < got; i++) begin
      dre = int'($signed(res[i][31:16])) - int'(a_re[i]);
      dim = int'($signed(res[i][15:0])) - int'(a_im[i]);
      checks++;
      if (dre > 2 || dre < -2 || dim > 2 || dim < -2) begin
        errors++; $display("FAIL rt_value[%0d] got=%h want=%h+-2", i, res[i], {a_re[i], a_im[i]});
      end
    end
  endtask

  task automatic test_reset_midstream();
    int cnt;
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.a32 = 32'h7FFF_8000;
    cnt = 0;
    do begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      cnt++;
    end while (!bus.out_valid && cnt < 10);
    @(negedge clk);
    checks++; if (bus.ovf !== 1'b1) begin errors++; $display("FAIL mid_ovf_pre got=%b want=1", bus.ovf); end
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.a32 = 32'h1000_0100 + 32'(i);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid got=%b want=0", bus.out_valid); end
    checks++; if (bus.r32 !== 32'h0) begin errors++; $display("FAIL mid_r32 got=%h want=00000000", bus.r32); end
    checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL mid_ovf got=%b want=0", bus.ovf); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a32 = 32'h4000_0000;
    cnt = 0;
    do begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      cnt++;
      checks++;
      if (cnt < STAGES && bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_replay cyc=%0d got=%b want=0", cnt, bus.out_valid); end
    end while (!bus.out_valid && cnt < 10);
    checks++; if (cnt !== STAGES) begin errors++; $display("FAIL mid_latency got=%0d want=%0d", cnt, STAGES); end
    checks++; if (bus.r32 !== 32'h2D41_2D41) begin errors++; $display("FAIL mid_r32_new got=%h want=2d412d41", bus.r32); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ovf();
    test_back_to_back();
    test_round_trip();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/complex_mult_twiddle_wn1conj_32b_pipe.md
# complex_mult_twiddle_wn1conj_32b_pipe

Pipelined streaming multiplier by the conjugate twiddle W8^1* = (1+j)/√2, the inverse-direction counterpart of the forward W8^1 = (1−j)/√2 rotator. It sits in the IFFT butterfly datapath, where conjugate twiddles undo the forward rotation. Unlike the combinational forward rotator, it registers three stages behind a valid/ready handshake and reports saturation events.

## Interface
- DATA_W, 16: width of each real/imag component (Q1.15 two's complement).
- K_HALFSQRT2, 16'h5A82: √2/2 in Q1.15 (23170).
- clk  in  1  rising-edge clock, the only clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  A32 carries a sample.
- in_ready  out  1  block accepts A32 this cycle.
- A32  in  32  input sample, {real[31:16], imag[15:0]}.
- out_valid  out  1  R32 carries a result.
- out_ready  in  1  sink accepts R32 this cycle.
- R32  out  32  result, {real[31:16], imag[15:0]}.
- ovf  out  1  sticky: at least one component saturated since reset or the last clear.
- clr_ovf  in  1  synchronous clear of ovf.

## Operation
- Math: for input a + jb, R = ((a−b)·k) + j((a+b)·k), with k = K_HALFSQRT2.
- Stage 1: d = a−b and s = a+b, both sign-extended to 17 bits, exact, registered with v1.
- Stage 2: pd = d·k and ps = s·k, signed 17×16 products, 33 bits, registered with v2.
- Stage 3:
  - Arithmetic shift right by 15, which truncates toward −∞.
  - Saturate to the 16-bit range [0x8000, 0x7FFF].
  - Register the result into R32 with v3 (= out_valid).
- Saturation pulse: set when either component clamped; registered alongside v3.
- ovf update:
  - Sets on the cycle a saturating sample is accepted by the sink (out_valid & out_ready).
  - clr_ovf has priority over set when both occur in the same cycle.
- Stall control: single global advance enable, adv = out_ready | ~out_valid.
  - in_ready = adv.
  - When adv is high, every stage loads from its predecessor; the v1 load value is in_valid & in_ready.
  - When adv is low, all stages hold data and valids unchanged.
- Bubbles are not collapsed, so throughput is 1 sample/cycle while out_ready stays high.

## Timing
- Reset (asynchronous, rst_n low):
  - v1, v2, v3 = 0; all data registers = 0.
  - Outputs: out_valid = 0, R32 = 0, ovf = 0, in_ready = 1.
- Latency: a sample accepted at edge N appears on R32 with out_valid = 1 after edge N+3, provided adv stays high.
- out_ready low with out_valid high: R32 and out_valid stay stable until accepted, and in_ready = 0 in the same cycle (combinational from out_ready).
- Accept and emit in the same cycle is legal and keeps full throughput.
- rst_n asserted mid-stream: in-flight samples are discarded and not replayed; ovf clears.
- in_valid low while adv is high: a bubble enters and appears 3 cycles later with out_valid = 0.

## Structure
- Shared package (fft_pkg):
  - DATA_W, K_HALFSQRT2 (16'h5A82), the stage count (3).
  - Packing helper for {real, imag}.
- One natural sub-module, sat_shr15_16b: 33-bit signed in, arithmetic shift right by 15, saturate to 16 bits, outputs value and sat flag.
  - Instantiated twice in stage 3.
- Stage-1 add/sub uses the existing 16-bit adder/subtractor cells, sign-extended to 17 bits.

## Test plan
- A32 = {0x4000, 0x0000}, out_ready = 1 → three cycles later R32 = {0x2D41, 0x2D41}, ovf = 0.
- A32 = {0x2000, 0x2000} → R32 = {0x0000, 0x2D41}. A32 = {0x0000, 0x0001} → R32 = {0xFFFF, 0x0000}, confirming truncation toward −∞.
- A32 = {0x7FFF, 0x8000} → R32 = {0x7FFF, 0xFFFF}, ovf = 1 after acceptance; pulse clr_ovf → ovf = 0 next cycle; clr_ovf coincident with a new saturation → ovf = 0.
- Stream 8 back-to-back samples, holding out_ready low for cycles 4–6 → in_ready low exactly while out_valid & ~out_ready, no sample lost or duplicated, order preserved.
- Compare a round trip through the forward W8^1 block and then this block against a reference model: output equals input within ±2 LSB per component for random non-saturating inputs.
- Assert rst_n with 3 samples in flight → out_valid = 0, R32 = 0, ovf = 0 immediately; after release the first new sample emerges 3 cycles after acceptance.
